// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FILL,
    RUN,
    ERROR
  } state_t;

  // Default fill word for unused program slots (zero-extended to WORD).
  localparam int unsigned NOP_DEFAULT = 0;

endpackage

// File: rtl/loader_addr_counter.sv
// Program write address and accepted-word counter with clear, separate
// increments and a terminal-count flag at the last program slot.
module loader_addr_counter
  import loader_pkg::*;
#(
  parameter int ADDR = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_clear,
  input  logic            i_inc_addr,
  input  logic            i_inc_count,
  output logic [ADDR-1:0] o_addr,
  output logic [ADDR:0]   o_count,
  output logic            o_terminal
);

  logic [ADDR-1:0] r_addr;
  logic [ADDR:0]   r_count;

  // Fill writes advance the address but not the count, hence two increments.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_addr  <= '0;
      r_count <= '0;
    end else begin
      if (i_inc_addr)
        r_addr <= r_addr + ADDR'(1);
      if (i_inc_count)
        r_count <= r_count + (ADDR+1)'(1);
    end
  end

  assign o_addr     = r_addr;
  assign o_count    = r_count;
  assign o_terminal = &r_addr;

endmodule

// File: rtl/program_loader.sv
// Streams program words into program memory while holding the CPU in reset.
// Define PROGRAM_LOADER_FILL_EN to pad unused slots with NOP_WORD after the last word.
module program_loader
  import loader_pkg::*;
#(
  parameter int              ADDR     = 8,
  parameter int              CODE     = 4,
  parameter int              WORD     = ADDR + CODE,
  parameter logic [WORD-1:0] NOP_WORD = WORD'(NOP_DEFAULT)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            word_valid,
  input  logic [WORD-1:0] word_data,
  input  logic            word_last,
  output logic            word_ready,
  output logic            program_write,
  output logic [ADDR-1:0] program_addr,
  output logic [WORD-1:0] program_cmd,
  output logic            cpu_hold,
  output logic            busy,
  output logic            done,
  output logic            error,
  output logic [ADDR:0]   word_count
);

  state_t          r_state;
  logic            r_word_ready;
  logic            r_write;
  logic [ADDR-1:0] r_addr;
  logic [WORD-1:0] r_cmd;
  logic            r_hold;
  logic            r_busy;
  logic            r_done;
  logic            r_error;

  logic            w_accept;
  logic            w_fill_step;
  logic [ADDR-1:0] w_addr;
  logic            w_term;

  // r_word_ready is high exactly while in LOAD, so it doubles as the state qualifier.
  assign w_accept    = r_word_ready & word_valid;
  assign w_fill_step = (r_state == FILL);

  loader_addr_counter #(
    .ADDR(ADDR)
  ) u_counter (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (start),
    .i_inc_addr  (w_accept | w_fill_step),
    .i_inc_count (w_accept),
    .o_addr      (w_addr),
    .o_count     (word_count),
    .o_terminal  (w_term)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_word_ready <= 1'b0;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_cmd        <= '0;
      r_hold       <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_write <= 1'b0;
      if (start) begin
        // Restart from any state; a word offered alongside start is dropped.
        r_state      <= LOAD;
        r_word_ready <= 1'b1;
        r_hold       <= 1'b1;
        r_busy       <= 1'b1;
        r_done       <= 1'b0;
        r_error      <= 1'b0;
      end else begin
        case (r_state)
          LOAD: begin
            if (w_accept) begin
              r_write <= 1'b1;
              r_addr  <= w_addr;
              r_cmd   <= word_data;
              if (word_last) begin
`ifdef PROGRAM_LOADER_FILL_EN
                if (!w_term) begin
                  r_state      <= FILL;
                  r_word_ready <= 1'b0;
                end else begin
                  r_state      <= RUN;
                  r_word_ready <= 1'b0;
                  r_hold       <= 1'b0;
                  r_busy       <= 1'b0;
                  r_done       <= 1'b1;
                end
`else
                r_state      <= RUN;
                r_word_ready <= 1'b0;
                r_hold       <= 1'b0;
                r_busy       <= 1'b0;
                r_done       <= 1'b1;
`endif
              end else if (w_term) begin
                r_state      <= ERROR;
                r_word_ready <= 1'b0;
                r_busy       <= 1'b0;
                r_error      <= 1'b1;
              end
            end
          end
`ifdef PROGRAM_LOADER_FILL_EN
          FILL: begin
            r_write <= 1'b1;
            r_addr  <= w_addr;
            r_cmd   <= NOP_WORD;
            if (w_term) begin
              r_state <= RUN;
              r_hold  <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign word_ready    = r_word_ready;
  assign program_write = r_write;
  assign program_addr  = r_addr;
  assign program_cmd   = r_cmd;
  assign cpu_hold      = r_hold;
  assign busy          = r_busy;
  assign done          = r_done;
  assign error         = r_error;

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader against a list-based session model.
module tb_program_loader;

  localparam int ADDR = 8;
  localparam int CODE = 4;
  localparam int WORD = ADDR + CODE;
  localparam logic [WORD-1:0] NOP = '0;
`ifdef PROGRAM_LOADER_FILL_EN
  localparam bit FILL_ON = 1'b1;
`else
  localparam bit FILL_ON = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset, start, word_valid, word_last;
  logic [WORD-1:0] word_data;
  logic            word_ready, program_write, cpu_hold, busy, done, error;
  logic [ADDR-1:0] program_addr;
  logic [WORD-1:0] program_cmd;
  logic [ADDR:0]   word_count;

  int total  = 0;
  int passed = 0;

  logic [ADDR+WORD-1:0] got_q[$];
  logic [ADDR+WORD-1:0] exp_q[$];

  program_loader #(.ADDR(ADDR), .CODE(CODE), .WORD(WORD), .NOP_WORD(NOP)) dut (
    .clk(clk), .reset(reset), .start(start), .word_valid(word_valid),
    .word_data(word_data), .word_last(word_last), .word_ready(word_ready),
    .program_write(program_write), .program_addr(program_addr),
    .program_cmd(program_cmd), .cpu_hold(cpu_hold), .busy(busy),
    .done(done), .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  // Record every memory write just after the edge that produced it.
  always @(posedge clk) begin
    #1;
    if (program_write) got_q.push_back({program_addr, program_cmd});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", passed, total);
    $fatal(1);
  end

  // Expected memory writes for one session: words land at consecutive
  // addresses from 0; a completed session optionally pads the rest with NOP.
  function automatic void model_session(input logic [WORD-1:0] words[$], input bit ended);
    exp_q.delete();
    foreach (words[i]) exp_q.push_back({ADDR'(i), words[i]});
    if (ended && FILL_ON)
      for (int a = words.size(); a < 2**ADDR; a++) exp_q.push_back({ADDR'(a), NOP});
  endfunction

  function automatic int first_diff();
    int n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) return i;
    if (got_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  task automatic pulse_start();
    start = 1'b1; word_valid = 1'b0; word_last = 1'b0;
    @(negedge clk);
    start = 1'b0;
    got_q.delete();
  endtask

  task automatic wait_done(input string name);
    for (int k = 0; k < 400 && !done; k++) @(negedge clk);
    total++;
    if (done !== 1'b1) $display("FAIL %s_done_timeout: done=%b required 1", name, done);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; word_valid = 1'b0; word_last = 1'b0; word_data = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({cpu_hold, word_ready, program_write, busy, done, error} !== 6'b100000)
      $display("FAIL reset_ctrl: hold/ready/wr/busy/done/err=%b required 100000",
               {cpu_hold, word_ready, program_write, busy, done, error});
    else passed++;
    total++;
    if ({program_addr, program_cmd, word_count} !== '0)
      $display("FAIL reset_data: addr=%0h cmd=%0h count=%0d required 0 0 0",
               program_addr, program_cmd, word_count);
    else passed++;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({cpu_hold, word_ready, busy, program_write} !== 4'b1000)
      $display("FAIL idle_hold: hold/ready/busy/wr=%b required 1000",
               {cpu_hold, word_ready, busy, program_write});
    else passed++;
  endtask

  task automatic test_basic();
    logic [WORD-1:0] w[$];
    int d;
    w = '{12'h101, 12'h202, 12'h303};
    pulse_start();
    total++;
    if ({busy, word_ready, cpu_hold, done, error, word_count} !== {5'b11100, 9'd0})
      $display("FAIL basic_load_entry: busy/ready/hold/done/err=%b count=%0d required 11100 0",
               {busy, word_ready, cpu_hold, done, error}, word_count);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      word_valid = 1'b1; word_data = w[i]; word_last = (i == 2);
      @(negedge clk);
      total++;
      if ({program_write, program_addr, program_cmd} !== {1'b1, ADDR'(i), w[i]})
        $display("FAIL basic_write%0d: wr=%b addr=%0d cmd=%0h required 1 %0d %0h",
                 i, program_write, program_addr, program_cmd, i, w[i]);
      else passed++;
      total++;
      if (word_count !== (ADDR+1)'(i + 1))
        $display("FAIL basic_count%0d: count=%0d required %0d", i, word_count, i + 1);
      else passed++;
    end
    word_valid = 1'b0; word_last = 1'b0;
    wait_done("basic");
    total++;
    if ({cpu_hold, busy, word_ready, error, word_count} !== {4'b0000, 9'd3})
      $display("FAIL basic_run: hold/busy/ready/err=%b count=%0d required 0000 3",
               {cpu_hold, busy, word_ready, error}, word_count);
    else passed++;
    @(negedge clk);
    total++;
    if (program_write !== 1'b0)
      $display("FAIL basic_run_nowrite: wr=%b required 0", program_write);
    else passed++;
    model_session(w, 1'b1);
    d = first_diff();
    total++;
    if (d != -1) $display("FAIL basic_trace: entry %0d differs, got %0d entries required %0d",
                          d, got_q.size(), exp_q.size());
    else passed++;
  endtask

  task automatic test_fill();
    logic [WORD-1:0] w[$];
    w = '{WORD'($urandom), WORD'($urandom)};
    pulse_start();
    for (int i = 0; i < 2; i++) begin
      word_valid = 1'b1; word_data = w[i]; word_last = (i == 1);
      @(negedge clk);
    end
    word_valid = 1'b0; word_last = 1'b0;
    if (FILL_ON) begin
      for (int k = 0; k < 254; k++) begin
        @(negedge clk);
        total++;
        if ({program_write, program_addr, program_cmd} !== {1'b1, ADDR'(k + 2), NOP})
          $display("FAIL fill_write%0d: wr=%b addr=%0d cmd=%0h required 1 %0d %0h",
                   k, program_write, program_addr, program_cmd, k + 2, NOP);
        else passed++;
      end
      total++;
      if ({done, cpu_hold, busy, word_count} !== {3'b100, 9'd2})
        $display("FAIL fill_end: done/hold/busy=%b count=%0d required 100 2",
                 {done, cpu_hold, busy}, word_count);
      else passed++;
    end else begin
      total++;
      if ({done, cpu_hold, busy, word_count} !== {3'b100, 9'd2})
        $display("FAIL nofill_run: done/hold/busy=%b count=%0d required 100 2",
                 {done, cpu_hold, busy}, word_count);
      else passed++;
    end
    repeat (3) @(negedge clk);
    total++;
    if (got_q.size() !== (FILL_ON ? 256 : 2))
      $display("FAIL fill_total_writes: got %0d required %0d", got_q.size(), FILL_ON ? 256 : 2);
    else passed++;
  endtask

  task automatic test_toggle();
    logic [WORD-1:0] w[$];
    int d;
    pulse_start();
    for (int c = 0; c < 10; c++) begin
      word_valid = (c % 2 == 0);
      word_data  = WORD'($urandom);
      word_last  = (c == 8);
      if (word_valid) w.push_back(word_data);
      @(negedge clk);
      total++;
      if (program_write !== (c % 2 == 0) ||
          (program_write && program_addr !== ADDR'(c / 2)))
        $display("FAIL toggle_cycle%0d: wr=%b addr=%0d required %b %0d",
                 c, program_write, program_addr, (c % 2 == 0), c / 2);
      else passed++;
    end
    word_valid = 1'b0; word_last = 1'b0;
    wait_done("toggle");
    model_session(w, 1'b1);
    d = first_diff();
    total++;
    if (d != -1) $display("FAIL toggle_trace: entry %0d differs, got %0d entries required %0d",
                          d, got_q.size(), exp_q.size());
    else passed++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      logic [WORD-1:0] w[$];
      int n, idx, d;
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) w.push_back(WORD'($urandom));
      pulse_start();
      idx = 0;
      for (int k = 0; k < 400 && idx < n; k++) begin
        word_valid = $urandom_range(0, 1);
        word_data  = w[idx];
        word_last  = (idx == n - 1);
        @(negedge clk);
        if (word_valid) idx++;
      end
      word_valid = 1'b0; word_last = 1'b0;
      wait_done("random");
      total++;
      if (word_count !== (ADDR+1)'(n))
        $display("FAIL random%0d_count: count=%0d required %0d", it, word_count, n);
      else passed++;
      model_session(w, 1'b1);
      d = first_diff();
      total++;
      if (d != -1) $display("FAIL random%0d_trace: entry %0d differs, got %0d entries required %0d",
                            it, d, got_q.size(), exp_q.size());
      else passed++;
    end
  endtask

  task automatic test_overflow();
    logic [WORD-1:0] w[$];
    int d, n_before;
    pulse_start();
    for (int i = 0; i < 256; i++) begin
      word_valid = 1'b1; word_last = 1'b0; word_data = WORD'($urandom);
      w.push_back(word_data);
      @(negedge clk);
    end
    word_valid = 1'b0;
    total++;
    if ({error, cpu_hold, busy, done, word_ready, word_count} !== {5'b11000, 9'd256})
      $display("FAIL overflow_state: err/hold/busy/done/ready=%b count=%0d required 11000 256",
               {error, cpu_hold, busy, done, word_ready}, word_count);
    else passed++;
    model_session(w, 1'b0);
    d = first_diff();
    total++;
    if (d != -1) $display("FAIL overflow_trace: entry %0d differs, got %0d entries required %0d",
                          d, got_q.size(), exp_q.size());
    else passed++;
    n_before = got_q.size();
    word_valid = 1'b1;
    repeat (3) @(negedge clk);
    word_valid = 1'b0;
    @(negedge clk);
    total++;
    if (got_q.size() !== n_before || error !== 1'b1)
      $display("FAIL overflow_ignore: writes %0d err=%b required %0d 1", got_q.size(), error, n_before);
    else passed++;
    pulse_start();
    total++;
    if ({busy, cpu_hold, error, word_ready, word_count} !== {4'b1101, 9'd0})
      $display("FAIL overflow_restart: busy/hold/err/ready=%b count=%0d required 1101 0",
               {busy, cpu_hold, error, word_ready}, word_count);
    else passed++;
  endtask

  task automatic test_restart_run();
    pulse_start();
    word_valid = 1'b1; word_data = 12'h5A5; word_last = 1'b1;
    @(negedge clk);
    word_valid = 1'b0; word_last = 1'b0;
    wait_done("restart");
    @(negedge clk);
    start = 1'b1; word_valid = 1'b1; word_data = 12'hABC; word_last = 1'b0;
    @(negedge clk);
    start = 1'b0;
    total++;
    if ({cpu_hold, done, busy, program_write, word_count} !== {4'b1010, 9'd0})
      $display("FAIL restart_entry: hold/done/busy/wr=%b count=%0d required 1010 0",
               {cpu_hold, done, busy, program_write}, word_count);
    else passed++;
    @(negedge clk);
    word_valid = 1'b0;
    total++;
    if ({program_write, program_addr, program_cmd} !== {1'b1, ADDR'(0), 12'hABC})
      $display("FAIL restart_addr0: wr=%b addr=%0d cmd=%0h required 1 0 abc",
               program_write, program_addr, program_cmd);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int n_after;
    pulse_start();
    for (int i = 0; i < 2; i++) begin
      word_valid = 1'b1; word_data = WORD'($urandom); word_last = 1'b0;
      @(negedge clk);
    end
    reset = 1'b1; start = 1'b1; word_valid = 1'b1; word_data = 12'hFFF;
    @(negedge clk);
    total++;
    if ({cpu_hold, word_ready, program_write, busy, done, error} !== 6'b100000)
      $display("FAIL resetmid_ctrl: hold/ready/wr/busy/done/err=%b required 100000",
               {cpu_hold, word_ready, program_write, busy, done, error});
    else passed++;
    total++;
    if ({program_addr, program_cmd, word_count} !== '0)
      $display("FAIL resetmid_data: addr=%0h cmd=%0h count=%0d required 0 0 0",
               program_addr, program_cmd, word_count);
    else passed++;
    n_after = got_q.size();
    reset = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    word_valid = 1'b0;
    total++;
    if (got_q.size() !== n_after || busy !== 1'b0 || cpu_hold !== 1'b1)
      $display("FAIL resetmid_idle: writes %0d busy=%b hold=%b required %0d 0 1",
               got_q.size(), busy, cpu_hold, n_after);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_toggle();
    test_random();
    test_overflow();
    test_restart_run();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter ADDR, default 8, program address width; 2**ADDR program slots.
REQ-002 Parameter CODE, default 4, opcode width.
REQ-003 Parameter WORD, default ADDR+CODE, program word width.
REQ-004 Parameter NOP_WORD, default all-zero WORD, fill word for unused slots.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  one-cycle pulse; begin a new load session.
REQ-008 word_valid  in  1  word_data holds a program word.
REQ-009 word_data  in  WORD  program word, opcode in upper CODE bits.
REQ-010 word_last  in  1  qualifies the current word as final word of the session.
REQ-011 word_ready  out  1  loader accepts a word this cycle.
REQ-012 program_write  out  1  write strobe to program memory.
REQ-013 program_addr  out  ADDR  program memory write address.
REQ-014 program_cmd  out  WORD  program memory write data.
REQ-015 cpu_hold  out  1  active-high; processor held in reset while asserted.
REQ-016 busy  out  1  session in progress (LOAD or FILL).
REQ-017 done  out  1  program loaded; processor running.
REQ-018 error  out  1  session aborted by overflow.
REQ-019 word_count  out  ADDR+1  words accepted in current or last session.

Function
REQ-020 States SHALL be IDLE, LOAD, FILL, RUN, ERROR.
REQ-021 IDLE: word_ready=0, cpu_hold=1; start -> LOAD next cycle, address and word_count cleared.
REQ-022 LOAD: word_ready=1; a word SHALL be accepted only when word_valid and word_ready both high.
REQ-023 Accepted word SHALL appear as program_write=1, program_cmd=word_data, program_addr=current address on the following cycle (1-cycle latency); program_write=0 otherwise.
REQ-024 Each accepted word SHALL increment address (mod 2**ADDR) and word_count by 1.
REQ-025 Accepted word with word_last=1 SHALL end LOAD: -> FILL if fill compiled in and address not at 2**ADDR-1, else -> RUN.
REQ-026 Accepted word at address 2**ADDR-1 without word_last SHALL -> ERROR; that word is still written.
REQ-027 word_valid with word_ready=0 SHALL be ignored; no buffering.
REQ-028 RUN: cpu_hold=0, done=1, word_ready=0, program_write=0.
REQ-029 ERROR: cpu_hold=1, error=1, word_ready=0; exit only on start (-> LOAD) or reset.
REQ-030 start in LOAD, FILL, RUN or ERROR SHALL restart the session: -> LOAD, cpu_hold=1 on next cycle, address and word_count cleared; no write is generated for a word offered in the start cycle.
REQ-031 busy=1 exactly in LOAD and FILL; done and error cleared on leaving RUN/ERROR.
REQ-032 cpu_hold SHALL be 1 in every state except RUN.

Reset
REQ-033 reset SHALL take priority over start and handshake in the same cycle.
REQ-034 Reset values: state IDLE, cpu_hold=1, word_ready=0, program_write=0, program_addr=0, program_cmd=0, busy=0, done=0, error=0, word_count=0.
REQ-035 reset mid-LOAD or mid-FILL SHALL abandon the session; no further writes.

Configuration
REQ-036 Macro PROGRAM_LOADER_FILL_EN defined: FILL writes NOP_WORD to each remaining address up to 2**ADDR-1, one per cycle, word_ready=0, then -> RUN; word_count not incremented by fill writes.
REQ-037 Macro undefined: FILL state absent; last word -> RUN directly; unused slots keep prior content.

Structure
REQ-038 Package loader_pkg SHALL hold the state enum typedef and the default NOP constant.
REQ-039 Sub-module loader_addr_counter SHALL hold the address/word_count register with clear, increment and terminal-count flag.

Verification
REQ-040 reset, start, 3 words 0x101,0x202,0x303 (last on third) -> writes at addr 0,1,2 one cycle after each accept; word_count=3; RUN with cpu_hold=0, done=1.
REQ-041 FILL_EN, 2 words then last -> NOP writes at addr 2..255 (254 cycles), then done=1.
REQ-042 256 words without word_last -> 256 writes, error=1, cpu_hold=1; start -> LOAD, word_count=0.
REQ-043 word_valid toggling every other cycle in LOAD -> only valid cycles written, addresses contiguous.
REQ-044 start in RUN -> cpu_hold=1 next cycle, done=0, busy=1, address 0.
REQ-045 reset asserted with start and word_valid same cycle mid-LOAD -> IDLE, no write next cycle, all outputs at reset values.
